// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width, STORE port address
// and the baud divisor helper used by the transmit and receive sides.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam logic [7:0] UART_STORE_ADDR = 8'hFE;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Integer divide; the result must be at least 2 for the bit timing to work.
  function automatic int calc_clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_unit_if.sv
// Control-unit side of the UART transmitter: data bus, load/send strobes and
// status returned to the control unit.
interface uart_tx_unit_if;
  import uart_pkg::*;

  // Handshake: uart_send_data is a one-cycle request that is accepted only
  // when busyFlag is low; busyFlag acts as not-ready and a request made while
  // it is high is dropped and recorded in tx_overrun. uart_tx_in is
  // always accepted and simply overwrites the holding register.
  logic [UART_DATA_W-1:0] data_in;
  logic                   uart_tx_in;
  logic                   uart_send_data;
  logic                   busyFlag;
  logic                   tx_done;
  logic                   tx_overrun;
  logic                   tx;

  modport master (
    output data_in, uart_tx_in, uart_send_data,
    input  busyFlag, tx_done, tx_overrun, tx
  );

  modport slave (
    input  data_in, uart_tx_in, uart_send_data,
    output busyFlag, tx_done, tx_overrun, tx
  );

endinterface

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of a
// bit; held at 0 while restart is high.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_restart,
  output logic o_bit_end
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n || i_restart) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_bit_end = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_unit.sv
// UART transmitter: double-buffered byte, LSB-first 8N1/8N2 framing.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_unit
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115_200,
  parameter int STOP_BITS   = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  uart_tx_unit_if.slave          bus,
  output state_t                 o_dbg_state,
  output logic [UART_DATA_W-1:0] o_dbg_holding
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam logic [2:0] LAST_IDX = 3'(UART_DATA_W - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  state_t                 r_state;
  logic [UART_DATA_W-1:0] r_holding;
  logic [UART_DATA_W-1:0] r_shifter;
  logic [2:0]             r_bit_idx;
  logic                   r_stop_cnt;
  logic                   r_tx;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_overrun;

  state_t                 w_state_nxt;
  logic [UART_DATA_W-1:0] w_shifter_nxt;
  logic [2:0]             w_idx_nxt;
  logic                   w_stop_nxt;
  logic                   w_tx_nxt;
  logic                   w_busy_nxt;
  logic                   w_done_nxt;
  logic                   w_bit_end;
  logic                   w_restart;

  // Holding the counter at 0 in IDLE makes the start bit a full bit period.
  assign w_restart = (r_state == IDLE);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_restart(w_restart),
    .o_bit_end(w_bit_end)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_shifter_nxt = r_shifter;
    w_idx_nxt     = r_bit_idx;
    w_stop_nxt    = r_stop_cnt;
    w_tx_nxt      = r_tx;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.uart_send_data) begin
          w_state_nxt   = START;
          w_shifter_nxt = r_holding;
          w_idx_nxt     = 3'd0;
          w_stop_nxt    = 1'b0;
          w_tx_nxt      = 1'b0;
          w_busy_nxt    = 1'b1;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
          w_idx_nxt   = 3'd0;
          w_tx_nxt    = r_shifter[0];
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = PARITY;
            w_tx_nxt    = ^r_shifter;
`else
            w_state_nxt = STOP;
            w_stop_nxt  = 1'b0;
            w_tx_nxt    = 1'b1;
`endif
          end else begin
            w_idx_nxt = r_bit_idx + 3'd1;
            w_tx_nxt  = r_shifter[r_bit_idx + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = STOP;
          w_stop_nxt  = 1'b0;
          w_tx_nxt    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          if (r_stop_cnt == STOP_LAST) begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_tx_nxt    = 1'b1;
          end else begin
            w_stop_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_holding  <= '0;
      r_shifter  <= '0;
      r_bit_idx  <= 3'd0;
      r_stop_cnt <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shifter  <= w_shifter_nxt;
      r_bit_idx  <= w_idx_nxt;
      r_stop_cnt <= w_stop_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      // The frame already latched its own copy, so the holding register is free.
      if (bus.uart_tx_in) begin
        r_holding <= bus.data_in;
      end
      if (bus.uart_send_data && r_busy) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign bus.tx         = r_tx;
  assign bus.busyFlag   = r_busy;
  assign bus.tx_done    = r_done;
  assign bus.tx_overrun = r_overrun;
  assign o_dbg_state    = r_state;
  assign o_dbg_holding  = r_holding;

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit at CLKS_PER_BIT=4, with a 1-stop-bit and a
// 2-stop-bit instance; parity frames are exercised when UART_TX_PARITY_EN is set.
module tb_uart_tx_unit;
  import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  uart_tx_unit_if bus1();
  uart_tx_unit_if bus2();
  state_t     dbg_state1, dbg_state2;
  logic [7:0] dbg_hold1, dbg_hold2;

  uart_tx_unit #(.CLK_FREQ_HZ(1000), .BAUD(250), .STOP_BITS(1)) u1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1),
    .o_dbg_state(dbg_state1), .o_dbg_holding(dbg_hold1)
  );

  uart_tx_unit #(.CLK_FREQ_HZ(1000), .BAUD(250), .STOP_BITS(2)) u2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2),
    .o_dbg_state(dbg_state2), .o_dbg_holding(dbg_hold2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [0:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input int sel, input logic [7:0] d, input logic ld, input logic sd);
    if (sel == 1) begin
      bus1.data_in = d; bus1.uart_tx_in = ld; bus1.uart_send_data = sd;
    end else begin
      bus2.data_in = d; bus2.uart_tx_in = ld; bus2.uart_send_data = sd;
    end
  endtask

  task automatic sample(input int sel, output logic tx, output logic busy, output logic done,
                        output logic ovr, output state_t st, output logic [7:0] hold);
    if (sel == 1) begin
      tx = bus1.tx; busy = bus1.busyFlag; done = bus1.tx_done;
      ovr = bus1.tx_overrun; st = dbg_state1; hold = dbg_hold1;
    end else begin
      tx = bus2.tx; busy = bus2.busyFlag; done = bus2.tx_done;
      ovr = bus2.tx_overrun; st = dbg_state2; hold = dbg_hold2;
    end
  endtask

  task automatic load(input int sel, input logic [7:0] d);
    drive(sel, d, 1'b1, 1'b0);
    @(negedge clk);
    drive(sel, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send(input int sel);
    drive(sel, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    drive(sel, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_load(input int sel, input logic [7:0] d);
    drive(sel, d, 1'b1, 1'b1);
    @(negedge clk);
    drive(sel, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_reset(input int sel, input string tag);
    logic tx, busy, done, ovr; state_t st; logic [7:0] hold;
    sample(sel, tx, busy, done, ovr, st, hold);
    chk({tag, " tx"}, 32'(tx), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " overrun"}, 32'(ovr), 32'd0);
    chk({tag, " state"}, 32'(st), 32'(IDLE));
    chk({tag, " holding"}, 32'(hold), 32'h00);
  endtask

  // Called one negedge after the accepting edge; ends one negedge after the
  // edge that should finish the frame. inj >= 0 fires load 0xFF + send there.
  task automatic check_frame(input int sel, input string tag, input logic [7:0] d,
                             input int stops, input int inj, input int exp_len);
    logic tx, busy, done, ovr; state_t st; logic [7:0] hold;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (PAR == 1) exp_q.push_back(^d);
    for (int s = 0; s < stops; s++) exp_q.push_back(1'b1);
    for (int c = 0; c < exp_len; c++) begin
      sample(sel, tx, busy, done, ovr, st, hold);
      chk($sformatf("%s tx@%0d", tag, c), 32'(tx), 32'(exp_q[c / 4]));
      chk($sformatf("%s busy@%0d", tag, c), 32'(busy), 32'd1);
      chk($sformatf("%s done@%0d", tag, c), 32'(done), 32'd0);
      if (c == inj) drive(sel, 8'hFF, 1'b1, 1'b1);
      @(negedge clk);
      if (c == inj) drive(sel, 8'h00, 1'b0, 1'b0);
    end
    sample(sel, tx, busy, done, ovr, st, hold);
    chk({tag, " end busy"}, 32'(busy), 32'd0);
    chk({tag, " end done"}, 32'(done), 32'd1);
    chk({tag, " end tx"}, 32'(tx), 32'd1);
    chk({tag, " end state"}, 32'(st), 32'(IDLE));
  endtask

  initial begin
    logic tx, busy, done, ovr; state_t st; logic [7:0] hold;
    reset_n = 1'b0;
    drive(1, 8'h00, 1'b0, 1'b0);
    drive(2, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_reset(1, "reset u1");
    check_reset(2, "reset u2");
    reset_n = 1'b1;
    @(negedge clk);

    // 1: 0xA5 -> 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit, 40-cycle frame
    load(1, 8'hA5);
    sample(1, tx, busy, done, ovr, st, hold);
    chk("t1 holding", 32'(hold), 32'hA5);
    send(1);
    check_frame(1, "t1", 8'hA5, 1, -1, 40 + 4 * PAR);
    @(negedge clk);
    sample(1, tx, busy, done, ovr, st, hold);
    chk("t1 done width", 32'(done), 32'd0);

`ifdef UART_TX_PARITY_EN
    // 2: parity bit 0 for 0xA5, 1 for 0x01, 44-cycle frames
    load(1, 8'hA5);
    send(1);
    check_frame(1, "t2a", 8'hA5, 1, -1, 44);
    @(negedge clk);
    load(1, 8'h01);
    send(1);
    check_frame(1, "t2b", 8'h01, 1, -1, 44);
    @(negedge clk);
`endif

    // 3: overrun at cycle 12, frame unchanged, back-to-back send carries 0xFF
    load(1, 8'h3C);
    send(1);
    sample(1, tx, busy, done, ovr, st, hold);
    chk("t3 overrun before", 32'(ovr), 32'd0);
    check_frame(1, "t3", 8'h3C, 1, 12, 40 + 4 * PAR);
    sample(1, tx, busy, done, ovr, st, hold);
    chk("t3 overrun", 32'(ovr), 32'd1);
    chk("t3 holding", 32'(hold), 32'hFF);
    send(1);
    check_frame(1, "t3b", 8'hFF, 1, -1, 40 + 4 * PAR);
    @(negedge clk);

    // 4: simultaneous load+send in IDLE sends the old holding value
    load(1, 8'h11);
    send_load(1, 8'h22);
    sample(1, tx, busy, done, ovr, st, hold);
    chk("t4 holding", 32'(hold), 32'h22);
    check_frame(1, "t4", 8'h11, 1, -1, 40 + 4 * PAR);
    @(negedge clk);

    // 5: reset at cycle 20 of a frame
    send(1);
    repeat (20) @(negedge clk);
    sample(1, tx, busy, done, ovr, st, hold);
    chk("t5 mid busy", 32'(busy), 32'd1);
    chk("t5 mid state", 32'(st), 32'(DATA));
    chk("t5 mid overrun", 32'(ovr), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset(1, "t5 after reset");
    reset_n = 1'b1;
    @(negedge clk);
    load(1, 8'h96);
    send(1);
    check_frame(1, "t5 resend", 8'h96, 1, -1, 40 + 4 * PAR);
    @(negedge clk);

    // 6: two stop bits, 0x00 -> 36 low, 8 high, 44-cycle frame
    load(2, 8'h00);
    send(2);
    check_frame(2, "t6", 8'h00, 2, -1, 44 + 4 * PAR);
    @(negedge clk);
    sample(2, tx, busy, done, ovr, st, hold);
    chk("t6 done width", 32'(done), 32'd0);
    chk("t6 overrun", 32'(ovr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
